// File: rtl/mult128_ctrl.sv
// ============================================================================
// Module      : mult128_ctrl
// Description : Sequencer for a chunked 128x128 multiplier: loads operands,
//               waits for FINAL, reads back the 256-bit product.
//               Optional WAIT timeout enabled by MULT128_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult128_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] op_a,
    input  logic [127:0] op_b,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [255:0] result,
    output logic [31:0]  in_loc,
    output logic [31:0]  in_val,
    output logic [31:0]  ctrl_reg,
    input  logic [31:0]  out_loc,
    input  logic [31:0]  out_val,
    input  logic [31:0]  state_reg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t       r_state;
    logic [2:0]   r_cnt;
    logic [255:0] r_ops;
    logic [255:0] r_result;
    logic         r_busy;
    logic         r_done;
    logic [31:0]  r_in_loc;
    logic [31:0]  r_in_val;
    logic [31:0]  r_ctrl;

    logic [2:0]   w_next;
    logic [2:0]   w_slot;
    logic         w_capture;
    logic         w_loc_ok;

    assign w_next    = r_cnt + 3'd1;
    // out_loc 1..8 maps to slot 0..7; the 3-bit wrap makes 8 land on slot 7
    assign w_slot    = out_loc[2:0] - 3'd1;
    assign w_loc_ok  = (out_loc >= 32'd1) && (out_loc <= 32'd8);
    // Multiplier answers one cycle after each read address, so the window
    // is shifted by one: READ cycles 1..7 plus DRAIN.
    assign w_capture = ((r_state == S_READ) && (r_cnt != 3'd0)) || (r_state == S_DRAIN);

`ifdef MULT128_CTRL_TIMEOUT_EN
    logic        r_err;
    logic [31:0] r_wcnt;
    assign err = r_err;
`else
    wire [31:0] w_unused_timeout = TIMEOUT_CYC;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_ops    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_in_loc <= 32'd0;
            r_in_val <= 32'd0;
            r_ctrl   <= 32'd0;
`ifdef MULT128_CTRL_TIMEOUT_EN
            r_err    <= 1'b0;
            r_wcnt   <= 32'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ops    <= {op_b, op_a};
                        r_state  <= S_LOAD;
                        r_busy   <= 1'b1;
                        r_cnt    <= 3'd0;
                        r_in_loc <= 32'd1;
                        r_in_val <= op_a[31:0];
                        r_ctrl   <= 32'd0;
`ifdef MULT128_CTRL_TIMEOUT_EN
                        r_err    <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (r_cnt == 3'd7) begin
                        r_state  <= S_WAIT;
                        r_ctrl   <= 32'd1;
                        r_in_loc <= 32'd0;
                        r_in_val <= 32'd0;
`ifdef MULT128_CTRL_TIMEOUT_EN
                        r_wcnt   <= 32'd0;
`endif
                    end else begin
                        r_cnt    <= w_next;
                        r_in_loc <= {29'd0, r_cnt} + 32'd2;
                        r_in_val <= r_ops[{w_next, 5'd0} +: 32];
                    end
                end
                S_WAIT: begin
                    if (state_reg == 32'd2) begin
                        r_state  <= S_READ;
                        r_cnt    <= 3'd0;
                        r_in_loc <= 32'd8;
                    end
`ifdef MULT128_CTRL_TIMEOUT_EN
                    else if (r_wcnt == 32'(TIMEOUT_CYC - 1)) begin
                        r_state  <= S_DONE;
                        r_ctrl   <= 32'd0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end else begin
                        r_wcnt   <= r_wcnt + 32'd1;
                    end
`endif
                end
                S_READ: begin
                    if (r_cnt == 3'd7) begin
                        r_state  <= S_DRAIN;
                        r_in_loc <= 32'd0;
                    end else begin
                        r_cnt    <= w_next;
                        r_in_loc <= {29'd0, r_cnt} + 32'd9;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_ctrl  <= 32'd0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ctrl  <= 32'd0;
                end
            endcase

            if (w_capture && w_loc_ok) begin
                r_result[{w_slot, 5'd0} +: 32] <= out_val;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign in_loc   = r_in_loc;
    assign in_val   = r_in_val;
    assign ctrl_reg = r_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_mult128_ctrl.sv
// ============================================================================
// Module      : tb_mult128_ctrl
// Description : Directed vector bench for mult128_ctrl with a multiplier stub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult128_ctrl;

    localparam int MULT_CYC = 18;   // stub busy time; gives 21 WAIT cycles
    localparam int WAIT_EXP = MULT_CYC + 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] op_a, op_b;
    logic         busy, done, err;
    logic [255:0] result;
    logic [31:0]  in_loc, in_val, ctrl_reg;
    logic [31:0]  out_loc, out_val, state_reg;

    int n_checks = 0;
    int n_fail   = 0;

    mult128_ctrl #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .err(err), .result(result),
        .in_loc(in_loc), .in_val(in_val), .ctrl_reg(ctrl_reg),
        .out_loc(out_loc), .out_val(out_val), .state_reg(state_reg)
    );

    always #5 clk = ~clk;

    // Multiplier stub: latches chunks while ctrl=0, runs MULT_CYC cycles,
    // then answers read addresses 8..15 one cycle later.
    logic [255:0] ld_flat;
    logic [255:0] prod;
    logic [1:0]   mstate;
    int           mcount;
    bit           stall = 1'b0;

    assign prod      = {128'd0, ld_flat[127:0]} * {128'd0, ld_flat[255:128]};
    assign state_reg = {30'd0, mstate};

    always @(posedge clk) begin
        if (reset || ctrl_reg == 32'd0) begin
            mstate  <= 2'd0;
            mcount  <= 0;
            out_loc <= 32'd0;
            out_val <= 32'd0;
            if (!reset && in_loc >= 32'd1 && in_loc <= 32'd8)
                ld_flat[(in_loc - 32'd1) * 32 +: 32] <= in_val;
        end else begin
            if (mstate == 2'd0 && !stall) begin
                mstate <= 2'd1;
                mcount <= 0;
            end else if (mstate == 2'd1) begin
                if (mcount == MULT_CYC) mstate <= 2'd2;
                else                    mcount <= mcount + 1;
            end
            if (in_loc >= 32'd8 && in_loc <= 32'd15) begin
                out_loc <= in_loc - 32'd7;
                out_val <= prod[(in_loc - 32'd8) * 32 +: 32];
            end else begin
                out_loc <= 32'd0;
                out_val <= 32'd0;
            end
        end
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] out_vec();
        return {136'd0, busy, done, err, in_loc, in_val, ctrl_reg} | result;
    endfunction

    task automatic run_job(input logic [127:0] a, input logic [127:0] b,
                           input logic [255:0] exp, input string nm);
        logic [255:0] ops;
        bit ok;
        int cyc;
        ops = {b, a};
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (in_loc != 32'(k + 1) || in_val != ops[k*32 +: 32] || ctrl_reg != 32'd0 || !busy)
                ok = 1'b0;
            @(negedge clk);
        end
        check({nm, " load"}, {255'd0, ok}, 256'd1);
        cyc = 0;
        while (in_loc == 32'd0 && ctrl_reg == 32'd1 && busy && !done && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check({nm, " wait_len"}, 256'(cyc), 256'(WAIT_EXP));
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (in_loc != 32'(8 + i) || ctrl_reg != 32'd1 || !busy || done) ok = 1'b0;
            @(negedge clk);
        end
        check({nm, " read"}, {255'd0, ok}, 256'd1);
        @(negedge clk);
        check({nm, " done_cyc"}, {252'd0, done, err, busy, ctrl_reg == 32'd0 && in_loc == 32'd0},
              256'b1011);
        check({nm, " result"}, result, exp);
        @(negedge clk);
        check({nm, " idle"}, {254'd0, done, busy}, 256'd0);
    endtask

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc, ndone;
        bit ok;

        vecs[0] = '{128'd1, 128'd1, 256'd1};
        vecs[1] = '{{128{1'b1}}, {128{1'b1}},
                    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001};
        vecs[2] = '{128'h1_00000000, 128'h1_00000000_00000000_00000000,
                    256'h1_00000000_00000000_00000000_00000000};
        vecs[3] = '{128'hFFFFFFFF, 128'hFFFFFFFF, 256'hFFFFFFFE_00000001};
        vecs[4] = '{128'h80000000_00000000_00000000_00000000, 128'd2,
                    256'h1_00000000_00000000_00000000_00000000};
        vecs[5] = '{128'h1_00000001, 128'hFFFFFFFF, 256'hFFFFFFFF_FFFFFFFF};
        vecs[6] = '{128'd0, {128{1'b1}}, 256'd0};

        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("reset_state", out_vec(), 256'd0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++)
            run_job(vecs[v].a, vecs[v].b, vecs[v].exp, $sformatf("vec%0d", v));

        // start held high: one job per IDLE visit, nothing queued
        @(negedge clk);
        op_a = 128'd7; op_b = 128'd6; start = 1'b1;
        cyc = 0; ndone = 0; ok = 1'b1;
        @(negedge clk);
        while (!done && cyc < 200) begin
            if (!busy) ok = 1'b0;
            cyc++;
            @(negedge clk);
        end
        check("held_busy", {255'd0, ok}, 256'd1);
        check("held_result", result, 256'd42);
        @(negedge clk);
        check("held_idle", {254'd0, busy, done}, 256'd0);
        @(negedge clk);
        check("held_restart", {255'd0, busy}, 256'd1);
        start = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("held_one_more_job", 256'(ndone), 256'd1);
        check("held_quiet", {255'd0, busy}, 256'd0);

        // reset in the middle of READ
        @(negedge clk);
        op_a = {128{1'b1}}; op_b = 128'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (in_loc != 32'd8 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("reach_read", {224'd0, in_loc}, 256'd8);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_read", out_vec(), 256'd0);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("no_done_after_abort", 256'(ndone), 256'd0);
        run_job(128'd3, 128'd5, 256'd15, "after_reset");
        check("err_default", {255'd0, err}, 256'd0);

`ifdef MULT128_CTRL_TIMEOUT_EN
        // multiplier never finishes: err exactly 64 cycles after WAIT entry
        stall = 1'b1;
        @(negedge clk);
        op_a = 128'd11; op_b = 128'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (ctrl_reg != 32'd1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        cyc = 0;
        while (!done && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        check("timeout_cycles", 256'(cyc), 256'd64);
        check("timeout_flags", {254'd0, done, err}, 256'b11);
        check("timeout_result", result, 256'd0);
        stall = 1'b0;
        repeat (2) @(negedge clk);
        op_a = 128'd4; op_b = 128'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_cleared", {255'd0, err}, 256'd0);
        repeat (60) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
